instr_fetch_mem: RTL and testbench

- Instruction-side storage and fetch registers for the MIPS CPU pipeline front end.
- Contains three pieces:
  - a byte-addressed, big-endian, word-access memory with a single read/write port;
  - a 32-bit PC register whose output addresses the memory;
  - a 32-bit instruction register capturing the memory read data.
- Used both to load the program (write mode) and to fetch instructions (read mode).

---
 rtl/instr_fetch_mem.sv | 99 +++++++++
 tb/tb_instr_fetch_mem.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: instruction-side memory, PC register and instruction
// register of the CPU front end.
//
// The memory is byte addressed and big-endian, and it is accessed one
// aligned word at a time through a single port. It is stored as an array
// of 32-bit words. Bits 31:24 of a word hold the byte at the lowest
// address, and bits 7:0 hold the byte at offset +3.
//
// The memory starts all-zero, and the program is loaded only through the
// write port.
module instr_fetch_mem #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_BYTES = 65536,
  parameter              INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] data_in,
  input  logic        rw,
  input  logic        en,
  output logic [31:0] pc_q,
  output logic [31:0] data_out,
  output logic [31:0] instr_q
);

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = $clog2(MEM_BYTES);
  localparam int          WORDS    = MEM_BYTES / 4;
  localparam logic [32:0] BASE_33  = {1'b0, BASE_ADDR};
  localparam logic [32:0] LIMIT_33 = 33'(MEM_BYTES);

  // Reject geometries that the word-index slicing cannot represent.
  if ((MEM_BYTES < 4) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_size
    $error("instr_fetch_mem: MEM_BYTES must be a power of two and at least 4");
  end

  // Word storage. Every word starts at zero so that unwritten locations
  // read back as 0.
  logic [DATA_W-1:0] mem_q [WORDS] = '{default: '0};

  if (INIT_FILE != "") begin : g_init_ignored
    $warning("instr_fetch_mem: INIT_FILE is ignored");
  end

  // Address decode. The arithmetic is done in 33 bits, so a PC below
  // BASE_ADDR, or one near the top of the 32-bit space, cannot wrap back
  // into the valid window.
  logic [32:0]       pc_33;
  logic [32:0]       off_33;
  logic              addr_ok;
  logic [ADDR_W-3:0] word_idx;
  logic              wr_en;

  assign pc_33    = {1'b0, pc_q};
  assign off_33   = pc_33 - BASE_33;
  assign addr_ok  = (pc_33 >= BASE_33) && (off_33 < LIMIT_33);
  // Offset bits 1:0 are dropped, so every access is word aligned.
  assign word_idx = off_33[ADDR_W-1:2];
  // An invalid address never qualifies a write, so out-of-range writes
  // are silently dropped.
  assign wr_en    = en && !rw && addr_ok;

  // Register next-state values.
  logic [DATA_W-1:0] pc_d;
  logic [DATA_W-1:0] instr_d;

  assign pc_d    = pc_in;
  assign instr_d = data_out;

  // Read port: combinational from pc_q. The port reads 0 when it is
  // disabled or when the address falls outside the memory window.
  always_comb begin
    data_out = '0;
    if (en && addr_ok) begin
      data_out = mem_q[word_idx];
    end
  end

  // Write port: the word at the current pc_q takes data_in on the edge.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[word_idx] <= data_in;
    end
  end

  // PC and instruction registers. Both load every cycle, and the async
  // reset overrides any clock edge while it is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= BASE_ADDR;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed testbench for instr_fetch_mem in its default build
// (BASE_ADDR = 0, MEM_BYTES = 65536, no preload).
module tb_instr_fetch_mem;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] data_in;
  logic        rw;
  logic        en;
  logic [31:0] pc_q;
  logic [31:0] data_out;
  logic [31:0] instr_q;

  int checks   = 0;
  int failures = 0;

  instr_fetch_mem #(
    .BASE_ADDR (32'h0000_0000),
    .MEM_BYTES (65536),
    .INIT_FILE ("")
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pc_in    (pc_in),
    .data_in  (data_in),
    .rw       (rw),
    .en       (en),
    .pc_q     (pc_q),
    .data_out (data_out),
    .instr_q  (instr_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then return at the
  // next falling edge, after the rising edge has taken effect.
  task automatic step(input logic [31:0] pc, input logic [31:0] d,
                      input logic r, input logic e);
    pc_in   = pc;
    data_in = d;
    rw      = r;
    en      = e;
    @(posedge clock);
    @(negedge clock);
  endtask

  logic [31:0] w;

  initial begin
    reset   = 1'b0;
    pc_in   = 32'h40;
    data_in = 32'h0;
    rw      = 1'b1;
    en      = 1'b0;
    @(negedge clock);

    // Reset: asserted mid-cycle, takes effect before any edge.
    step(32'h40, 32'h0, 1'b1, 1'b0);
    chk("pc_before_reset", pc_q, 32'h40);
    #2 reset = 1'b1;
    #1;
    chk("pc_async_reset", pc_q, 32'h0);
    chk("instr_async_reset", instr_q, 32'h0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("pc_reset_held", pc_q, 32'h0);
    chk("instr_reset_held", instr_q, 32'h0);
    reset = 1'b0;

    // Program load. Each write lands at the pc_q registered on the
    // previous edge.
    step(32'h0, 32'h2402000A, 1'b0, 1'b1);  // pc_q 0 -> 0
    step(32'h4, 32'h2402000A, 1'b0, 1'b1);  // writes word 0; pc_q -> 4
    chk("pc_after_release", pc_q, 32'h4);
    step(32'h8, 32'h00431020, 1'b0, 1'b1);  // writes word 4; pc_q -> 8
    step(32'h8, 32'h11223344, 1'b0, 1'b1);  // writes word 8
    chk("wr_mode_readback", data_out, 32'h11223344);

    // Byte order in storage: byte 8 = 0x11, byte 11 = 0x44.
    w = dut.mem_q[2];
    chk("byte8", {24'h0, w[31:24]}, 32'h11);
    chk("byte11", {24'h0, w[7:0]}, 32'h44);

    // Fetch: data_out follows pc_q, and instr_q follows one edge later.
    step(32'h0, 32'h0, 1'b1, 1'b1);
    chk("rd0_data", data_out, 32'h2402000A);
    chk("rd0_instr_prev", instr_q, 32'h11223344);
    step(32'h4, 32'h0, 1'b1, 1'b1);
    chk("seq_instr0", instr_q, 32'h2402000A);
    chk("rd4_data", data_out, 32'h00431020);
    step(32'hA, 32'h0, 1'b1, 1'b1);
    chk("seq_instr1", instr_q, 32'h00431020);
    chk("misaligned_rd", data_out, 32'h11223344);

    // Enable low: the read returns 0, and a write attempt is ignored.
    step(32'hA, 32'h0, 1'b1, 1'b0);
    chk("en0_data", data_out, 32'h0);
    chk("en0_instr", instr_q, 32'h0);
    step(32'h8, 32'hDEADBEEF, 1'b0, 1'b0);
    step(32'h8, 32'hDEADBEEF, 1'b0, 1'b0);
    step(32'h8, 32'h0, 1'b1, 1'b1);
    chk("en0_write_blocked", data_out, 32'h11223344);

    // Window limit: BASE_ADDR + MEM_BYTES is invalid, and a write there is
    // dropped rather than aliased onto word 0.
    step(32'h10000, 32'h0, 1'b1, 1'b1);
    chk("oob_read", data_out, 32'h0);
    step(32'h10000, 32'hCAFEF00D, 1'b0, 1'b1);
    step(32'h0, 32'h0, 1'b1, 1'b1);
    chk("oob_write_dropped", data_out, 32'h2402000A);

    // Last valid word, then a PC at the top of the address space.
    step(32'hFFFC, 32'h0, 1'b1, 1'b1);
    chk("last_word_empty", data_out, 32'h0);
    step(32'hFFFC, 32'h55AA55AA, 1'b0, 1'b1);
    chk("last_word_write", data_out, 32'h55AA55AA);
    step(32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1);
    chk("pc_top_verbatim", pc_q, 32'hFFFF_FFFC);
    chk("pc_top_read", data_out, 32'h0);
    chk("instr_last_word", instr_q, 32'h55AA55AA);

    // Reset clears the registers but leaves memory intact.
    #2 reset = 1'b1;
    #1;
    chk("pc_reset2", pc_q, 32'h0);
    chk("instr_reset2", instr_q, 32'h0);
    chk("mem_kept_on_reset", data_out, 32'h2402000A);
    @(negedge clock);
    reset = 1'b0;
    step(32'h4, 32'h0, 1'b1, 1'b1);
    chk("post_reset_fetch", instr_q, 32'h2402000A);
    chk("post_reset_data", data_out, 32'h00431020);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
